// File: rtl/ram_dump_streamer_pkg.sv
// Shared definitions for the RAM debug-port dump streamer: FSM state codes,
// frame header byte and the running checksum helper.
package ram_dump_streamer_pkg;

    typedef logic [2:0] dump_state_t;

    localparam dump_state_t ST_IDLE      = 3'd0;
    localparam dump_state_t ST_WAIT_HALT = 3'd1;
    localparam dump_state_t ST_HEADER    = 3'd2;
    localparam dump_state_t ST_ADDR      = 3'd3;
    localparam dump_state_t ST_LOAD      = 3'd4;
    localparam dump_state_t ST_SEND      = 3'd5;
    localparam dump_state_t ST_CSUM      = 3'd6;
    localparam dump_state_t ST_DONE      = 3'd7;

    localparam logic [7:0] DUMP_HEADER_BYTE = 8'hA5;

    // Frame checksum is a plain modulo-256 byte sum; the header is excluded.
    function automatic logic [7:0] csum_add(input logic [7:0] sum, input logic [7:0] data);
        return sum + data;
    endfunction

endpackage

// File: rtl/ram_dump_streamer.sv
// Walks a window of data RAM through the debug port after the CPU halts and
// streams it as header, little-endian bytes and checksum over valid/ready.
module ram_dump_streamer
    import ram_dump_streamer_pkg::*;
#(
    parameter int FirstWord   = 0,
    parameter int NumWords    = 256,
    parameter int AddrWidth   = 8,
    parameter int ReadLatency = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic                 cpuHalted,
    output logic                 ramDebugEn,
    output logic [AddrWidth-1:0] ramAddr,
    output logic [1:0]           ramByteSel,
    input  logic [7:0]           ramData,
    output logic [7:0]           txData,
    output logic                 txValid,
    input  logic                 txReady,
    output logic                 busy,
    output logic                 done
);

    localparam int LatW = (ReadLatency > 1) ? $clog2(ReadLatency) : 1;
    // One extra bit so the last-word compare never wraps at the top of RAM.
    localparam logic [AddrWidth:0] FIRST_WORD = (AddrWidth + 1)'(FirstWord);
    localparam logic [AddrWidth:0] LAST_WORD  = (AddrWidth + 1)'(FirstWord + NumWords - 1);
    localparam logic [LatW-1:0]    LAT_START  = LatW'(ReadLatency - 1);

    dump_state_t        state;
    logic [AddrWidth:0] word;
    logic [1:0]         byte_sel;
    logic [LatW-1:0]    lat_cnt;
    logic [7:0]         checksum;
    logic               handshake;

    assign handshake  = txValid && txReady;
    assign ramAddr    = word[AddrWidth-1:0];
    assign ramByteSel = byte_sel;
    assign busy       = (state != ST_IDLE) && (state != ST_DONE);
    assign done       = (state == ST_DONE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_IDLE;
            word       <= FIRST_WORD;
            byte_sel   <= 2'd0;
            lat_cnt    <= '0;
            checksum   <= 8'd0;
            txData     <= 8'd0;
            txValid    <= 1'b0;
            ramDebugEn <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) state <= ST_WAIT_HALT;
                end
                ST_WAIT_HALT: begin
                    if (cpuHalted) begin
                        state      <= ST_HEADER;
                        ramDebugEn <= 1'b1;
                        txData     <= DUMP_HEADER_BYTE;
                        txValid    <= 1'b1;
                    end
                end
                ST_HEADER: begin
                    if (handshake) begin
                        state    <= ST_ADDR;
                        word     <= FIRST_WORD;
                        byte_sel <= 2'd0;
                        checksum <= 8'd0;
                        lat_cnt  <= LAT_START;
                        txValid  <= 1'b0;
                    end
                end
                ST_ADDR: begin
                    if (lat_cnt == '0) state <= ST_LOAD;
                    else               lat_cnt <= lat_cnt - 1'b1;
                end
                ST_LOAD: begin
                    txData   <= ramData;
                    checksum <= csum_add(checksum, ramData);
                    txValid  <= 1'b1;
                    state    <= ST_SEND;
                end
                ST_SEND: begin
                    if (handshake) begin
                        txValid <= 1'b0;
                        // Next lane of the same registered word is available at once.
                        if (byte_sel != 2'd3) begin
                            byte_sel <= byte_sel + 2'd1;
                            state    <= ST_LOAD;
                        end else if (word < LAST_WORD) begin
                            word     <= word + 1'b1;
                            byte_sel <= 2'd0;
                            lat_cnt  <= LAT_START;
                            state    <= ST_ADDR;
                        end else begin
                            txData  <= checksum;
                            txValid <= 1'b1;
                            state   <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (handshake) begin
                        txValid    <= 1'b0;
                        ramDebugEn <= 1'b0;
                        state      <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ram_dump_streamer.sv
// Directed bench for ram_dump_streamer: a low-window instance and a
// top-of-RAM instance share one registered-read RAM model.
module tb_ram_dump_streamer;

    logic        clk = 1'b0;
    logic        reset, start, start_hi, cpuHalted, txReady;

    logic        ram_debug_en, tx_valid, busy, done;
    logic [7:0]  ram_addr, ram_data, tx_data;
    logic [1:0]  ram_byte_sel;
    logic        ram_debug_en_hi, tx_valid_hi, busy_hi, done_hi;
    logic [7:0]  ram_addr_hi, ram_data_hi, tx_data_hi;
    logic [1:0]  ram_byte_sel_hi;

    logic [31:0] mem [256];
    logic [31:0] ram_word, ram_word_hi;

    bit          use_hi;
    logic        m_valid, m_done;
    logic [7:0]  m_data;

    int          checks, failures;
    logic [7:0]  got[$];
    int          done_pulses, done_gap, stall_err;

    always #5 clk = ~clk;

    ram_dump_streamer #(.FirstWord(0), .NumWords(2), .AddrWidth(8), .ReadLatency(1)) dut (
        .clk(clk), .reset(reset), .start(start), .cpuHalted(cpuHalted),
        .ramDebugEn(ram_debug_en), .ramAddr(ram_addr), .ramByteSel(ram_byte_sel),
        .ramData(ram_data), .txData(tx_data), .txValid(tx_valid), .txReady(txReady),
        .busy(busy), .done(done)
    );

    ram_dump_streamer #(.FirstWord(255), .NumWords(1), .AddrWidth(8), .ReadLatency(1)) dut_hi (
        .clk(clk), .reset(reset), .start(start_hi), .cpuHalted(cpuHalted),
        .ramDebugEn(ram_debug_en_hi), .ramAddr(ram_addr_hi), .ramByteSel(ram_byte_sel_hi),
        .ramData(ram_data_hi), .txData(tx_data_hi), .txValid(tx_valid_hi), .txReady(txReady),
        .busy(busy_hi), .done(done_hi)
    );

    always @(posedge clk) begin
        ram_word    <= mem[ram_addr];
        ram_word_hi <= mem[ram_addr_hi];
    end
    assign ram_data    = ram_word[{ram_byte_sel, 3'b000} +: 8];
    assign ram_data_hi = ram_word_hi[{ram_byte_sel_hi, 3'b000} +: 8];

    assign m_valid = use_hi ? tx_valid_hi : tx_valid;
    assign m_data  = use_hi ? tx_data_hi  : tx_data;
    assign m_done  = use_hi ? done_hi     : done;

    // Runs from the current negedge until done plus a few cycles, recording accepted bytes.
    task automatic run_frame(input bit toggle_ready, input int pulse_at, input int pulse2_at);
        int   last_hs, done_at;
        bit   prev_stall;
        logic [7:0] prev_data;
        got.delete();
        done_pulses = 0; done_gap = -1; stall_err = 0;
        last_hs = -1; done_at = -1; prev_stall = 1'b0; prev_data = 8'd0;
        for (int iter = 0; iter < 400; iter++) begin
            txReady = toggle_ready ? (iter % 2 == 0) : 1'b1;
            if (use_hi) start_hi = (iter == pulse_at) || (iter == pulse2_at);
            else        start    = (iter == pulse_at) || (iter == pulse2_at);
            if (prev_stall && (!m_valid || m_data !== prev_data)) stall_err++;
            if (m_valid && txReady) begin
                got.push_back(m_data);
                last_hs = iter;
            end
            prev_stall = m_valid && !txReady;
            prev_data  = m_data;
            if (m_done) begin
                done_pulses++;
                if (done_at < 0) begin
                    done_at  = iter;
                    done_gap = iter - last_hs;
                end
            end
            if (done_at >= 0 && iter >= done_at + 5) break;
            @(negedge clk);
        end
        start = 1'b0; start_hi = 1'b0;
    endtask

    task automatic test_reset();
        use_hi = 1'b0; start = 1'b0; start_hi = 1'b0; cpuHalted = 1'b0; txReady = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || ram_debug_en !== 1'b0 || busy !== 1'b0 || done !== 1'b0) begin
            failures++;
            $display("FAIL reset_ctrl valid=%b dbg=%b busy=%b done=%b required 0,0,0,0",
                     tx_valid, ram_debug_en, busy, done);
        end
        checks++;
        if (ram_addr !== 8'd0 || ram_byte_sel !== 2'd0 || tx_data !== 8'd0) begin
            failures++;
            $display("FAIL reset_data addr=%h sel=%h data=%h required 00,0,00", ram_addr, ram_byte_sel, tx_data);
        end
        checks++;
        if (ram_addr_hi !== 8'hFF || tx_valid_hi !== 1'b0) begin
            failures++;
            $display("FAIL reset_hi addr=%h valid=%b required ff,0", ram_addr_hi, tx_valid_hi);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic();
        logic [7:0] exp[$];
        int bad;
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        cpuHalted = 1'b1;
        run_frame(1'b0, 0, -1);
        bad = -1;
        for (int i = 0; i < exp.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != exp.size()) begin
            failures++;
            $display("FAIL basic_bytes idx=%0d got=%h required=%h len=%0d required_len=%0d", bad,
                     (bad >= 0 && bad < got.size()) ? got[bad] : 8'h00, (bad >= 0) ? exp[bad] : 8'h00,
                     got.size(), exp.size());
        end
        checks++;
        if (done_gap != 1 || done_pulses != 1) begin
            failures++;
            $display("FAIL basic_done gap=%0d pulses=%0d required 1,1", done_gap, done_pulses);
        end
    endtask

    task automatic test_wait_halt();
        int bad_cycles;
        logic [7:0] exp[$];
        int bad;
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        cpuHalted = 1'b0; txReady = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        bad_cycles = 0;
        for (int i = 0; i < 20; i++) begin
            if (tx_valid !== 1'b0 || ram_debug_en !== 1'b0 || busy !== 1'b1) bad_cycles++;
            @(negedge clk);
        end
        checks++;
        if (bad_cycles != 0) begin
            failures++;
            $display("FAIL halt_wait bad_cycles=%0d required 0", bad_cycles);
        end
        cpuHalted = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b1 || tx_data !== 8'hA5 || ram_debug_en !== 1'b1) begin
            failures++;
            $display("FAIL halt_header valid=%b data=%h dbg=%b required 1,a5,1", tx_valid, tx_data, ram_debug_en);
        end
        run_frame(1'b0, -1, -1);
        bad = -1;
        for (int i = 0; i < exp.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != exp.size()) begin
            failures++;
            $display("FAIL halt_bytes idx=%0d len=%0d required_len=%0d", bad, got.size(), exp.size());
        end
    endtask

    task automatic test_backpressure();
        logic [7:0] exp[$];
        int bad;
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        cpuHalted = 1'b1;
        run_frame(1'b1, 0, -1);
        bad = -1;
        for (int i = 0; i < exp.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != exp.size()) begin
            failures++;
            $display("FAIL bp_bytes idx=%0d len=%0d required_len=%0d", bad, got.size(), exp.size());
        end
        checks++;
        if (stall_err != 0) begin
            failures++;
            $display("FAIL bp_stable changes_while_stalled=%0d required 0", stall_err);
        end
        checks++;
        if (done_gap != 1 || done_pulses != 1) begin
            failures++;
            $display("FAIL bp_done gap=%0d pulses=%0d required 1,1", done_gap, done_pulses);
        end
    endtask

    task automatic test_reset_mid_dump();
        bit found;
        logic [7:0] exp[$];
        int bad;
        exp = '{8'hA5, 8'h11, 8'h22, 8'h33, 8'h44, 8'h55, 8'h66, 8'h77, 8'h88, 8'h64};
        cpuHalted = 1'b1; txReady = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 50 && !found; i++) begin
            if (tx_valid && ram_byte_sel == 2'd3) found = 1'b1;
            else @(negedge clk);
        end
        checks++;
        if (!found) begin
            failures++;
            $display("FAIL midreset_reach byte3_seen=%b required 1", found);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if (tx_valid !== 1'b0 || ram_debug_en !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL midreset_abort valid=%b dbg=%b busy=%b required 0,0,0", tx_valid, ram_debug_en, busy);
        end
        reset = 1'b0;
        @(negedge clk);
        run_frame(1'b0, 0, -1);
        bad = -1;
        for (int i = 0; i < exp.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != exp.size()) begin
            failures++;
            $display("FAIL midreset_restart idx=%0d len=%0d required_len=%0d", bad, got.size(), exp.size());
        end
    endtask

    task automatic test_top_of_ram();
        logic [7:0] exp[$];
        int bad;
        exp = '{8'hA5, 8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'hFC};
        cpuHalted = 1'b1;
        use_hi = 1'b1;
        run_frame(1'b0, 0, -1);
        use_hi = 1'b0;
        bad = -1;
        for (int i = 0; i < exp.size(); i++)
            if (bad < 0 && (i >= got.size() || got[i] !== exp[i])) bad = i;
        checks++;
        if (bad >= 0 || got.size() != exp.size()) begin
            failures++;
            $display("FAIL top_bytes idx=%0d got=%h required=%h len=%0d required_len=%0d", bad,
                     (bad >= 0 && bad < got.size()) ? got[bad] : 8'h00, (bad >= 0) ? exp[bad] : 8'h00,
                     got.size(), exp.size());
        end
        checks++;
        if (ram_addr_hi !== 8'hFF || done_pulses != 1) begin
            failures++;
            $display("FAIL top_addr addr=%h pulses=%0d required ff,1", ram_addr_hi, done_pulses);
        end
    endtask

    task automatic test_start_while_busy();
        int late_busy;
        cpuHalted = 1'b1;
        run_frame(1'b0, 0, 8);
        checks++;
        if (got.size() != 10 || done_pulses != 1) begin
            failures++;
            $display("FAIL busy_start len=%0d pulses=%0d required 10,1", got.size(), done_pulses);
        end
        late_busy = 0;
        for (int i = 0; i < 30; i++) begin
            if (busy !== 1'b0 || tx_valid !== 1'b0 || done !== 1'b0) late_busy++;
            @(negedge clk);
        end
        checks++;
        if (late_busy != 0) begin
            failures++;
            $display("FAIL busy_second_frame active_cycles=%0d required 0", late_busy);
        end
    endtask

    initial begin
        checks = 0; failures = 0;
        for (int i = 0; i < 256; i++) mem[i] = 32'hC0DE0000 | i;
        mem[0]   = 32'h44332211;
        mem[1]   = 32'h88776655;
        mem[255] = 32'hFFFFFFFF;
        reset = 1'b1;
        @(negedge clk);
        test_reset();
        test_basic();
        test_wait_halt();
        test_backpressure();
        test_reset_mid_dump();
        test_top_of_ram();
        test_start_while_busy();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
